// File: rtl/bullet_scheduler.sv
// Bullet-slot pool scheduler: per frame tick, arbitrates fire requests into
// free slots, then sweeps every slot once to advance or retire its bullet.
module bullet_scheduler #(
   parameter int NSLOT          = 16,
   parameter int MAX_PER_PLAYER = 8,
   parameter int COOLDOWN       = 12,
   parameter int SPEED          = 4,
   parameter int SCREEN_W       = 640,
   parameter int SCREEN_H       = 480,
   parameter int BW             = 8,
   parameter int BH             = 6,
   parameter int SPAWN_DX       = 12,
   parameter int SPAWN_DY       = 13,
   localparam int IW            = $clog2(NSLOT)
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          f_tick,
   input  logic [1:0]    fire_req,
   input  logic [9:0]    p1_x,
   input  logic [9:0]    p2_x,
   input  logic [9:0]    p1_y,
   input  logic [9:0]    p2_y,
   input  logic [1:0]    p1_dir,
   input  logic [1:0]    p2_dir,
   input  logic          kill_en,
   input  logic [IW-1:0] kill_idx,
   output logic          wr_en,
   output logic [IW-1:0] wr_idx,
   output logic [31:0]   wr_data,
   output logic [1:0]    fire_ack,
   output logic          busy,
   output logic [3:0]    live_cnt1,
   output logic [3:0]    live_cnt2
);

   // state  | meaning
   // IDLE   | waiting for f_tick; services kill requests
   // ALLOC0 | outputs show the first-served player's grant (rr player)
   // ALLOC1 | outputs show the second-served player's grant
   // MOVE   | outputs show the sweep write of slot sidx
   typedef enum logic [1:0] {IDLE, ALLOC0, ALLOC1, MOVE} state_t;

   localparam logic [3:0]    CAP     = 4'(MAX_PER_PLAYER);
   localparam logic [3:0]    CD_LOAD = 4'(COOLDOWN);
   localparam logic [10:0]   STEP    = 11'(SPEED);
   localparam logic [10:0]   X_MAX   = 11'(SCREEN_W - BW);
   localparam logic [10:0]   Y_MAX   = 11'(SCREEN_H - BH);
   localparam logic [9:0]    DX      = 10'(SPAWN_DX);
   localparam logic [9:0]    DY      = 10'(SPAWN_DY);
   localparam logic [IW-1:0] LAST    = IW'(NSLOT - 1);

   state_t           state;
   logic [IW-1:0]    sidx;
   logic [NSLOT-1:0] s_v;
   logic [NSLOT-1:0] s_own;
   logic [1:0]       s_dir [NSLOT];
   logic [9:0]       s_x   [NSLOT];
   logic [9:0]       s_y   [NSLOT];
   logic [3:0]       cd    [2];
   logic [3:0]       live  [2];
   logic [1:0]       pend;
   logic             rr;
   logic             first;

   logic [1:0]    pend_eff;
   logic          sp;
   logic          free_any;
   logic [IW-1:0] free_idx;
   logic          grant;
   logic          serve_now;
   logic [9:0]    sp_x, sp_y, spawn_x, spawn_y;
   logic [1:0]    sp_dir;
   logic [IW-1:0] mv_idx;
   logic          move_now;
   logic [10:0]   mx, my, nx, ny;
   logic          mv_die;

   assign live_cnt1 = live[0];
   assign live_cnt2 = live[1];

   // Registered outputs present the action of the state being entered, so
   // grant and sweep decisions are made from the next-state's point of view.
   always_comb begin
      pend_eff  = pend | {fire_req[1] & (cd[1] == 4'd0), fire_req[0] & (cd[0] == 4'd0)};
      sp        = (state == IDLE) ? rr : ~first;
      serve_now = ((state == IDLE) && f_tick) || (state == ALLOC0);
      free_any  = 1'b0;
      free_idx  = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (!s_v[i]) begin
            free_any = 1'b1;
            free_idx = IW'(i);
         end
      end
      grant   = pend_eff[sp] && (live[sp] < CAP) && free_any;
      sp_x    = sp ? p2_x : p1_x;
      sp_y    = sp ? p2_y : p1_y;
      sp_dir  = sp ? p2_dir : p1_dir;
      spawn_x = sp_x + DX;
      spawn_y = sp_y + DY;

      mv_idx   = (state == ALLOC1) ? '0 : sidx + IW'(1);
      move_now = (state == ALLOC1) || ((state == MOVE) && (sidx != LAST));
      mx       = {1'b0, s_x[mv_idx]};
      my       = {1'b0, s_y[mv_idx]};
      nx       = mx;
      ny       = my;
      case (s_dir[mv_idx])
         2'd0:    ny = my - STEP;
         2'd1:    nx = mx + STEP;
         2'd2:    ny = my + STEP;
         default: nx = mx - STEP;
      endcase
      mv_die = nx[10] | ny[10] | (nx > X_MAX) | (ny > Y_MAX);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state    <= IDLE;
         sidx     <= '0;
         s_v      <= '0;
         s_own    <= '0;
         for (int i = 0; i < NSLOT; i++) begin
            s_dir[i] <= '0;
            s_x[i]   <= '0;
            s_y[i]   <= '0;
         end
         cd[0]    <= '0;
         cd[1]    <= '0;
         live[0]  <= '0;
         live[1]  <= '0;
         pend     <= '0;
         rr       <= 1'b0;
         first    <= 1'b0;
         wr_en    <= 1'b0;
         wr_idx   <= '0;
         wr_data  <= '0;
         fire_ack <= '0;
         busy     <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         wr_idx   <= '0;
         wr_data  <= '0;
         fire_ack <= '0;
         pend     <= pend_eff;

         case (state)
            IDLE: begin
               if (f_tick) begin
                  state <= ALLOC0;
                  busy  <= 1'b1;
                  first <= rr;
                  for (int p = 0; p < 2; p++) begin
                     if (cd[p] != 4'd0) cd[p] <= cd[p] - 4'd1;
                  end
                  if ((pend_eff == 2'b11) && grant) rr <= ~rr;
               end else if (kill_en) begin
                  // a kill coinciding with f_tick is dropped: the port belongs to ALLOC0
                  wr_en  <= 1'b1;
                  wr_idx <= kill_idx;
                  if (s_v[kill_idx]) begin
                     s_v[kill_idx]             <= 1'b0;
                     live[s_own[kill_idx]]     <= live[s_own[kill_idx]] - 4'd1;
                  end
               end
            end
            ALLOC0: state <= ALLOC1;
            ALLOC1: begin
               state <= MOVE;
               sidx  <= '0;
            end
            MOVE: begin
               if (sidx == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  sidx <= mv_idx;
               end
            end
            default: state <= IDLE;
         endcase

         if (serve_now) begin
            pend[sp] <= 1'b0;
            if (grant) begin
               s_v[free_idx]   <= 1'b1;
               s_own[free_idx] <= sp;
               s_dir[free_idx] <= sp_dir;
               s_x[free_idx]   <= spawn_x;
               s_y[free_idx]   <= spawn_y;
               wr_en           <= 1'b1;
               wr_idx          <= free_idx;
               wr_data         <= {1'b1, sp, sp_dir, spawn_x, spawn_y, 8'h00};
               fire_ack[sp]    <= 1'b1;
               cd[sp]          <= CD_LOAD;
               live[sp]        <= live[sp] + 4'd1;
            end
         end

         if (move_now) begin
            wr_en  <= 1'b1;
            wr_idx <= mv_idx;
            if (s_v[mv_idx]) begin
               if (mv_die) begin
                  s_v[mv_idx]          <= 1'b0;
                  live[s_own[mv_idx]]  <= live[s_own[mv_idx]] - 4'd1;
               end else begin
                  s_x[mv_idx] <= nx[9:0];
                  s_y[mv_idx] <= ny[9:0];
                  wr_data     <= {1'b1, s_own[mv_idx], s_dir[mv_idx], nx[9:0], ny[9:0], 8'h00};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Bench for bullet_scheduler: slot-pool model checked against the DUT every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bullet_scheduler;

   logic        clk = 1'b0, clrn = 1'b0, f_tick = 1'b0, kill_en = 1'b0;
   logic [1:0]  fire_req = 2'b00;
   logic [9:0]  p1_x = 10'd100, p1_y = 10'd200, p2_x = 10'd300, p2_y = 10'd100;
   logic [1:0]  p1_dir = 2'd1, p2_dir = 2'd0;
   logic [3:0]  kill_idx = 4'd0;
   logic        wr_en, busy;
   logic [3:0]  wr_idx, live_cnt1, live_cnt2;
   logic [31:0] wr_data;
   logic [1:0]  fire_ack;

   bullet_scheduler dut (
      .clk(clk), .clrn(clrn), .f_tick(f_tick), .fire_req(fire_req),
      .p1_x(p1_x), .p2_x(p2_x), .p1_y(p1_y), .p2_y(p2_y),
      .p1_dir(p1_dir), .p2_dir(p2_dir), .kill_en(kill_en), .kill_idx(kill_idx),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .fire_ack(fire_ack),
      .busy(busy), .live_cnt1(live_cnt1), .live_cnt2(live_cnt2)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int busy_cnt = 0, wr_cnt = 0;

   logic        exp_wr_en = 1'b0, exp_busy = 1'b0;
   logic [3:0]  exp_wr_idx = 4'd0, exp_l1 = 4'd0, exp_l2 = 4'd0;
   logic [31:0] exp_wr_data = 32'd0;
   logic [1:0]  exp_ack = 2'd0;

   // pool model
   bit mv [16];
   int mown [16], mdir [16], mx [16], my [16];
   int mcd [2], mlive [2];
   bit mpend [2];
   int mrr, last_slot;

   always @(negedge clk) begin
      n_vec++;
      if ({wr_en, wr_idx, wr_data, fire_ack, busy, live_cnt1, live_cnt2} !==
          {exp_wr_en, exp_wr_idx, exp_wr_data, exp_ack, exp_busy, exp_l1, exp_l2}) begin
         n_err++;
         $display("FAIL outputs t=%0t: got en=%b idx=%0d data=%h ack=%b busy=%b l1=%0d l2=%0d, want en=%b idx=%0d data=%h ack=%b busy=%b l1=%0d l2=%0d",
                  $time, wr_en, wr_idx, wr_data, fire_ack, busy, live_cnt1, live_cnt2,
                  exp_wr_en, exp_wr_idx, exp_wr_data, exp_ack, exp_busy, exp_l1, exp_l2);
      end
      if (busy === 1'b1) busy_cnt++;
      if (wr_en === 1'b1) wr_cnt++;
   end

   task automatic check(input string name, input int act, input int expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", name, act, expv);
      end
   endtask

   function automatic logic [31:0] word(input int own, input int dir, input int x, input int y);
      return {1'b1, 1'(own), 2'(dir), 10'(x), 10'(y), 8'h00};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         mv[i] = 0; mown[i] = 0; mdir[i] = 0; mx[i] = 0; my[i] = 0;
      end
      for (int p = 0; p < 2; p++) begin
         mcd[p] = 0; mlive[p] = 0; mpend[p] = 0;
      end
      mrr = 0;
      last_slot = -1;
   endtask

   task automatic zero_exp();
      exp_wr_en = 0; exp_wr_idx = 0; exp_wr_data = 0; exp_ack = 0;
      exp_busy = 0; exp_l1 = 0; exp_l2 = 0;
   endtask

   task automatic expect_out(input bit w, input int idx, input logic [31:0] d,
                             input logic [1:0] ack, input bit b);
      @(posedge clk);
      #1;
      exp_wr_en = w; exp_wr_idx = 4'(idx); exp_wr_data = d; exp_ack = ack;
      exp_busy = b; exp_l1 = 4'(mlive[0]); exp_l2 = 4'(mlive[1]);
   endtask

   task automatic pend_upd();
      for (int p = 0; p < 2; p++)
         if (fire_req[p] && mcd[p] == 0) mpend[p] = 1;
   endtask

   task automatic serve(input int p, output bit w, output int idx, output logic [31:0] d,
                        output logic [1:0] ack, output bit granted);
      int fr, px, py, pd;
      w = 0; idx = 0; d = 0; ack = 0; granted = 0; fr = -1;
      for (int i = 15; i >= 0; i--) if (!mv[i]) fr = i;
      if (p == 0) begin px = p1_x; py = p1_y; pd = p1_dir; end
      else        begin px = p2_x; py = p2_y; pd = p2_dir; end
      if (mpend[p] && mlive[p] < 8 && fr >= 0) begin
         granted = 1; w = 1; idx = fr;
         mv[fr] = 1; mown[fr] = p; mdir[fr] = pd;
         mx[fr] = (px + 12) % 1024; my[fr] = (py + 13) % 1024;
         d = word(p, pd, mx[fr], my[fr]);
         ack[p] = 1'b1;
         mcd[p] = 12;
         mlive[p]++;
         last_slot = fr;
      end
      mpend[p] = 0;
   endtask

   task automatic move(input int i, output logic [31:0] d);
      int x, y;
      d = 0;
      if (mv[i]) begin
         x = mx[i]; y = my[i];
         case (mdir[i])
            0: y -= 4;
            1: x += 4;
            2: y += 4;
            default: x -= 4;
         endcase
         if (x < 0 || y < 0 || x > 640 - 8 || y > 480 - 6) begin
            mv[i] = 0;
            mlive[mown[i]]--;
         end else begin
            mx[i] = x; my[i] = y;
            d = word(mown[i], mdir[i], x, y);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         pend_upd();
         expect_out(0, 0, 0, 0, 0);
      end
   endtask

   task automatic kill(input int k);
      kill_en = 1; kill_idx = 4'(k);
      pend_upd();
      if (mv[k]) begin
         mv[k] = 0;
         mlive[mown[k]]--;
      end
      expect_out(1, k, 0, 0, 0);
      kill_en = 0;
   endtask

   task automatic do_reset();
      clrn = 0;
      zero_exp();
      model_reset();
      #1;
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1 clrn = 1;
   endtask

   // one full frame; ftick_at/kill_at inject ignored pulses, abort_at resets after that edge
   task automatic frame(input int ftick_at, input int kill_at, input int kidx, input int abort_at);
      bit w, g, both;
      int idx, first;
      logic [31:0] d;
      logic [1:0] ack;
      f_tick = 1;
      pend_upd();
      first = mrr;
      both = mpend[0] && mpend[1];
      for (int p = 0; p < 2; p++) if (mcd[p] > 0) mcd[p]--;
      serve(first, w, idx, d, ack, g);
      if (both && g) mrr = 1 - mrr;
      expect_out(w, idx, d, ack, 1);
      f_tick = 0;
      pend_upd();
      serve(1 - first, w, idx, d, ack, g);
      expect_out(w, idx, d, ack, 1);
      for (int e = 2; e < 18; e++) begin
         if (e == ftick_at) f_tick = 1;
         if (e == kill_at) begin kill_en = 1; kill_idx = 4'(kidx); end
         pend_upd();
         move(e - 2, d);
         expect_out(1, e - 2, d, 0, 1);
         f_tick = 0; kill_en = 0;
         if (e == abort_at) begin
            #1 clrn = 0;
            zero_exp();
            model_reset();
            #1;
            check("abort_wr_en", int'(wr_en), 0);
            check("abort_wr_data", int'(wr_data), 0);
            check("abort_busy", int'(busy), 0);
            check("abort_live1", int'(live_cnt1), 0);
            @(posedge clk);
            #1 clrn = 1;
            return;
         end
      end
      pend_upd();
      expect_out(0, 0, 0, 0, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_wr_en", int'(wr_en), 0);
      check("reset_wr_idx", int'(wr_idx), 0);
      check("reset_wr_data", int'(wr_data), 0);
      check("reset_fire_ack", int'(fire_ack), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_live", int'(live_cnt1) + int'(live_cnt2), 0);
      clrn = 1;
      idle(2);

      // empty frame
      busy_cnt = 0; wr_cnt = 0;
      frame(-1, -1, 0, -1);
      check("empty_busy_cycles", busy_cnt, 18);
      check("empty_writes", wr_cnt, 16);

      // single p1 fire, cooldown
      fire_req = 2'b01;
      idle(1);
      frame(-1, -1, 0, -1);
      check("p1_slot0_x_after_move", mx[0], 116);
      check("p1_slot0_y", my[0], 213);
      check("p1_live_after_fire", int'(live_cnt1), 1);
      for (int i = 0; i < 12; i++) begin
         idle(2);
         frame(-1, -1, 0, -1);
      end
      check("p1_cooldown_expired", mcd[0], 0);
      check("p1_no_ack_in_cooldown", int'(live_cnt1), 1);
      idle(2);
      frame(-1, -1, 0, -1);
      check("p1_regrant_live", int'(live_cnt1), 2);
      check("p1_regrant_slot", last_slot, 1);
      fire_req = 2'b00;

      // joint fire and round robin
      do_reset();
      fire_req = 2'b11;
      idle(1);
      frame(-1, -1, 0, -1);
      check("joint_slot0_owner", mown[0], 0);
      check("joint_slot1_owner", mown[1], 1);
      check("joint_live2", int'(live_cnt2), 1);
      fire_req = 2'b00;
      for (int i = 0; i < 12; i++) begin
         idle(1);
         frame(-1, -1, 0, -1);
      end
      fire_req = 2'b11;
      idle(1);
      frame(-1, -1, 0, -1);
      check("rr_p2_slot2_owner", mown[2], 1);
      check("rr_p1_slot3_owner", mown[3], 0);
      check("rr_live2", int'(live_cnt2), 2);
      fire_req = 2'b00;

      // screen edges
      do_reset();
      p1_x = 10'd618; p1_y = 10'd200; p1_dir = 2'd1;
      p2_x = 10'd300; p2_y = 10'd2;   p2_dir = 2'd0;
      fire_req = 2'b11;
      idle(1);
      frame(-1, -1, 0, -1);
      fire_req = 2'b00;
      check("right_edge_retired", int'(live_cnt1), 0);
      check("up_y_after_1", my[1], 11);
      idle(1); frame(-1, -1, 0, -1);
      idle(1); frame(-1, -1, 0, -1);
      check("up_y_at_3", my[1], 3);
      check("up_alive", int'(live_cnt2), 1);
      idle(1); frame(-1, -1, 0, -1);
      check("up_underflow_retired", int'(live_cnt2), 0);

      // per-player cap, kill, refill
      do_reset();
      p1_x = 10'd20; p1_y = 10'd200; p1_dir = 2'd1;
      fire_req = 2'b01;
      idle(1);
      for (int f = 0; f < 120 && mlive[0] < 8; f++) begin
         frame(-1, -1, 0, -1);
         idle(1);
      end
      check("cap_reached", int'(live_cnt1), 8);
      for (int f = 0; f < 14; f++) begin
         frame(-1, -1, 0, -1);
         idle(1);
      end
      check("cap_cooldown_zero", mcd[0], 0);
      check("cap_live_held", int'(live_cnt1), 8);
      kill(3);
      check("kill_live", int'(live_cnt1), 7);
      idle(1);
      frame(-1, -1, 0, -1);
      check("refill_slot", last_slot, 3);
      check("refill_live", int'(live_cnt1), 8);
      fire_req = 2'b00;

      // f_tick and kill during MOVE are ignored
      idle(1);
      busy_cnt = 0;
      frame(6, 8, 0, -1);
      check("move_ignore_busy", busy_cnt, 18);
      check("move_ignore_live", int'(live_cnt1), 8);
      idle(3);

      // reset mid-sweep, then a clean sweep
      frame(-1, -1, 0, 9);
      idle(2);
      busy_cnt = 0; wr_cnt = 0;
      frame(-1, -1, 0, -1);
      check("post_abort_writes", wr_cnt, 16);
      check("post_abort_live", int'(live_cnt1), 0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Owns the shared bullet-slot pool that feeds the bullet sprite OAM.
- On every frame tick it arbitrates fire requests from the two players, allocates free slots and spawns bullets at the shooter's tank.
- It then walks all slots once, advancing each live bullet and retiring any that leave the screen.
- Sits inside the game engine between the PS/2 key levels and the bullet RAM read by the bullet sprite engine.

Parameters:
NSLOT, 16, total bullet slots (2 x MAX_BULLETS)
MAX_PER_PLAYER, 8, live-bullet cap per player
COOLDOWN, 12, frames between successive grants to one player
SPEED, 4, pixels moved per frame
SCREEN_W, 640, visible width
SCREEN_H, 480, visible height
BW, 8, bullet tile width
BH, 6, bullet tile height
SPAWN_DX, 12, x offset from tank origin to bullet origin
SPAWN_DY, 13, y offset from tank origin to bullet origin

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
f_tick  in  1  one-cycle frame-start pulse
fire_req  in  2  held fire key level, [0]=player1, [1]=player2
p1_x, p2_x  in  10  tank origin x
p1_y, p2_y  in  10  tank origin y
p1_dir, p2_dir  in  2  tank facing: 0 up, 1 right, 2 down, 3 left
kill_en  in  1  clear slot kill_idx (hit detected)
kill_idx  in  log2(NSLOT)  slot to clear
wr_en  out  1  bullet RAM write strobe
wr_idx  out  log2(NSLOT)  bullet RAM slot address
wr_data  out  32  slot word: [31] valid, [30] owner, [29:28] dir, [27:18] x, [17:8] y, [7:0] 0
fire_ack  out  2  one-cycle pulse when a player's bullet is spawned
busy  out  1  high from first ALLOC cycle through last MOVE cycle
live_cnt1, live_cnt2  out  4  live bullets per player

Behaviour:
- Reset (clrn low, async): all slots invalid; cooldowns 0; pending 0; rr pointer = player1; state IDLE.
- Reset values: wr_en=0, wr_idx=0, wr_data=0, fire_ack=0, busy=0, live counts 0.
- Reset mid-frame abandons the sweep. RAM contents are not cleared by reset; the next sweep rewrites every slot.
- Setting pending[p]: any cycle with fire_req[p]=1 and cooldown[p]=0.
- Clearing pending[p]: in the ALLOC cycle that serves p, whether granted or refused.
- FSM states: IDLE -> ALLOC0 -> ALLOC1 -> MOVE -> IDLE.
- IDLE: f_tick moves to ALLOC0 next cycle. f_tick while busy is ignored.
- IDLE, kill_en=1: the slot is invalidated and wr_en writes it with word 0 in the same cycle; the owner's live count is decremented.
- kill_en while busy is ignored. A kill on an already-invalid slot only rewrites 0.
- ALLOC0/ALLOC1 serve one player each. Order is rr first, then the other player. rr toggles only when both were pending and the first-served player was granted.
- Grant condition: pending[p], live_cnt[p] < MAX_PER_PLAYER, and some slot free.
- Grant actions: take the lowest-index free slot. Write {1, p, dir_p, x_p+SPAWN_DX, y_p+SPAWN_DY} to internal state and to the RAM port. Pulse fire_ack[p] that cycle, reload cooldown[p]=COOLDOWN, increment live_cnt.
- Refusal (cap or pool full): no write, no ack, no cooldown reload.
- Cooldown: every nonzero cooldown decrements once per accepted f_tick, in ALLOC0.
- MOVE runs NSLOT cycles, idx 0..NSLOT-1, one slot per cycle, wr_en=1 every cycle; slots spawned this frame are moved too.
- MOVE arithmetic, in 11 bits: up y-SPEED, down y+SPEED, left x-SPEED, right x+SPEED.
- MOVE retire rule: the bullet dies (word written with valid=0, live count decremented) on underflow, x > SCREEN_W-BW, or y > SCREEN_H-BH. Otherwise the new position is written with valid=1.
- Invalid slots in MOVE are written as 0.
- Latency: f_tick at cycle T; ALLOC at T+1..T+2; MOVE at T+3..T+2+NSLOT; IDLE at T+3+NSLOT; busy high T+1..T+2+NSLOT.

Test Plan:
- Reset, then one f_tick with no fire -> busy high 18 cycles; 16 writes of 0 for idx 0..15; live counts 0.
- p1 at (100,200) dir right, fire_req[0] held, f_tick -> ALLOC0: fire_ack[0]; slot0 written x=112, y=213. MOVE idx0 writes x=116. No further ack until 12 more ticks.
- Both players fire, same tick, pool empty -> p1 gets slot0 (ALLOC0), p2 gets slot1 (ALLOC1). Next joint fire after cooldown -> p2 served in ALLOC0 and gets slot2.
- Bullet dir up at y=3 -> MOVE writes valid=0; live count drops by 1.
- Bullet dir right at x=630 -> MOVE writes valid=0; live count drops by 1.
- p1 holding 8 live bullets fires -> no ack, cooldown stays 0. kill_en idx of one p1 slot in IDLE -> slot written 0. Next tick -> p1 granted that lowest free slot.
- f_tick and kill_en asserted during MOVE -> both ignored: sweep completes unchanged, killed slot still valid.
- clrn asserted at MOVE idx 7 -> outputs 0 immediately. The next tick's sweep writes 0 to all 16 slots.
